instr_mem_loader: RTL and testbench

Parametrised instruction memory for the 16-bit datapath: 4-bit opcode, 2-bit register field, 10-bit operand. It replaces the fixed, initial-block-filled ROM with a reset-cleared, run-time-loadable memory. The fetch port is registered, and a load port uses a valid/ready handshake. It sits between the program-counter/fetch stage and the test/boot loader.

---
 rtl/instr_mem_loader_if.sv | 41 ++++
 rtl/instr_mem_loader.sv | 166 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Fetch and load port bundle for the run-time loadable instruction memory.
// The master side is the fetch stage / boot loader; the slave side is the memory.
interface instr_mem_loader_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 5
);
    // Mode status
    logic              busy;

    // Registered fetch port
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [WORD_W-1:0] fetch_instr;
    logic              fetch_err;

    // Load port with valid/ready handshake
    logic              load_en;
    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [WORD_W-1:0] load_data;
    logic              load_err;
    logic [ADDR_W:0]   load_count;

    modport master (
        input  busy,
        input  fetch_valid, fetch_instr, fetch_err,
        input  load_ready, load_err, load_count,
        output fetch_req, fetch_addr,
        output load_en, load_valid, load_addr, load_data
    );

    modport slave (
        output busy,
        output fetch_valid, fetch_instr, fetch_err,
        output load_ready, load_err, load_count,
        input  fetch_req, fetch_addr,
        input  load_en, load_valid, load_addr, load_data
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction memory for the 16-bit datapath.
// After reset the array is swept with NOP_WORD (CLEAR), then it serves
// registered fetches (RUN) or accepts write beats from the boot loader (LOAD).
// DEPTH must not exceed 2**ADDR_W; addresses at or above DEPTH never alias
// onto implemented words: fetches return NOP_WORD with fetch_err, load beats
// are dropped with load_err.
module instr_mem_loader #(
    parameter int                WORD_W   = 16,
    parameter int                ADDR_W   = 5,
    parameter int                DEPTH    = 32,
    parameter logic [WORD_W-1:0] NOP_WORD = WORD_W'(16'hF000)
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_mem_loader_if.slave bus
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Unsigned range test; the extra MSB keeps DEPTH == 2**ADDR_W representable.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    // Beat counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic              load_first;

    logic [WORD_W-1:0] mem [DEPTH];

    // Stage 0: requests accepted at this edge
    logic              fetch_vld_p0;
    logic              beat_vld_p0;
    logic              beat_in_rng_p0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic              busy_c;
    logic              load_ready_c;

    // Stage 1: registered results
    logic              fetch_vld_p1;
    logic              fetch_err_p1;
    logic [WORD_W-1:0] fetch_instr_p1;
    logic              load_err_p1;
    logic [ADDR_W:0]   load_cnt_p1;

    // State register and clear pointer; reset restarts the NOP sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            clr_ptr    <= '0;
            load_first <= 1'b0;
        end else begin
            state      <= state_nxt;
            load_first <= (state != ST_LOAD) && (state_nxt == ST_LOAD);
            if (state == ST_CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
            end
        end
    end

    // Next state, handshake, and single shared write port selection.
    always_comb begin
        state_nxt      = state;
        busy_c         = 1'b1;
        load_ready_c   = 1'b0;
        fetch_vld_p0   = 1'b0;
        beat_vld_p0    = 1'b0;
        beat_in_rng_p0 = in_range(bus.load_addr);
        mem_we         = 1'b0;
        mem_waddr      = clr_ptr;
        mem_wdata      = NOP_WORD;
        case (state)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (clr_ptr == LAST_ADDR) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_c       = 1'b0;
                fetch_vld_p0 = bus.fetch_req;
                if (bus.load_en) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_ready_c = bus.load_en;
                beat_vld_p0  = bus.load_valid & bus.load_en;
                if (beat_vld_p0 && beat_in_rng_p0) begin
                    mem_we    = 1'b1;
                    mem_waddr = bus.load_addr;
                    mem_wdata = bus.load_data;
                end
                if (!bus.load_en) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Memory array write: NOP sweep during CLEAR, accepted in-range beats during LOAD.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered fetch: instruction holds between fetches, valid/err pulse for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_vld_p1   <= 1'b0;
            fetch_err_p1   <= 1'b0;
            fetch_instr_p1 <= NOP_WORD;
        end else begin
            fetch_vld_p1 <= fetch_vld_p0;
            fetch_err_p1 <= fetch_vld_p0 & ~in_range(bus.fetch_addr);
            if (fetch_vld_p0) begin
                fetch_instr_p1 <= in_range(bus.fetch_addr) ? mem[bus.fetch_addr] : NOP_WORD;
            end
        end
    end

    // Load status: drop pulse for out-of-range beats, saturating in-range beat count
    // that restarts on the first edge spent in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_err_p1 <= 1'b0;
            load_cnt_p1 <= '0;
        end else begin
            load_err_p1 <= beat_vld_p0 & ~beat_in_rng_p0;
            if (state == ST_LOAD) begin
                if (beat_vld_p0 && beat_in_rng_p0) begin
                    load_cnt_p1 <= sat_inc(load_first ? '0 : load_cnt_p1);
                end else if (load_first) begin
                    load_cnt_p1 <= '0;
                end
            end
        end
    end

    assign bus.busy        = busy_c;
    assign bus.load_ready  = load_ready_c;
    assign bus.fetch_valid = fetch_vld_p1;
    assign bus.fetch_err   = fetch_err_p1;
    assign bus.fetch_instr = fetch_instr_p1;
    assign bus.load_err    = load_err_p1;
    assign bus.load_count  = load_cnt_p1;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: instance A (ADDR_W=5, DEPTH=32) and
// instance B (ADDR_W=6, DEPTH=40) share one clock with separate resets.
module tb_instr_mem_loader;

    typedef struct {
        string nm;
        bit    fr;
        int    fa;
        bit    le;
        bit    lv;
        int    la;
        int    ld;
        bit    rdy;
        bit    ev;
        int    ei;
        bit    efe;
        bit    ele;
        int    ec;
        bit    eb;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [15:0] instr;
        logic        ferr;
        logic        lerr;
        logic [6:0]  count;
        logic        busy;
        logic        ready;
    } out_t;

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;
    int   n_chk;
    int   n_fail;

    instr_mem_loader_if #(.WORD_W(16), .ADDR_W(5)) bus_a ();
    instr_mem_loader_if #(.WORD_W(16), .ADDR_W(6)) bus_b ();

    instr_mem_loader #(.WORD_W(16), .ADDR_W(5), .DEPTH(32), .NOP_WORD(16'hF000)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (bus_a)
    );

    instr_mem_loader #(.WORD_W(16), .ADDR_W(6), .DEPTH(40), .NOP_WORD(16'hF000)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got time limit reached, required test completion");
        $fatal(1, "simulation time limit");
    end

    function automatic vec_t mk(string nm, bit fr, int fa, bit le, bit lv, int la, int ld,
                                bit rdy, bit ev, int ei, bit efe, bit ele, int ec, bit eb);
        vec_t v;
        v.nm = nm; v.fr = fr; v.fa = fa; v.le = le; v.lv = lv; v.la = la; v.ld = ld;
        v.rdy = rdy; v.ev = ev; v.ei = ei; v.efe = efe; v.ele = ele; v.ec = ec; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit b, input bit fr, input int fa, input bit le,
                         input bit lv, input int la, input int ld);
        if (b) begin
            bus_b.fetch_req  = fr;
            bus_b.fetch_addr = 6'(fa);
            bus_b.load_en    = le;
            bus_b.load_valid = lv;
            bus_b.load_addr  = 6'(la);
            bus_b.load_data  = 16'(ld);
        end else begin
            bus_a.fetch_req  = fr;
            bus_a.fetch_addr = 5'(fa);
            bus_a.load_en    = le;
            bus_a.load_valid = lv;
            bus_a.load_addr  = 5'(la);
            bus_a.load_data  = 16'(ld);
        end
    endtask

    task automatic sample(input bit b, output out_t o);
        if (b) begin
            o.valid = bus_b.fetch_valid; o.instr = bus_b.fetch_instr; o.ferr = bus_b.fetch_err;
            o.lerr  = bus_b.load_err;    o.count = bus_b.load_count;  o.busy = bus_b.busy;
            o.ready = bus_b.load_ready;
        end else begin
            o.valid = bus_a.fetch_valid; o.instr = bus_a.fetch_instr; o.ferr = bus_a.fetch_err;
            o.lerr  = bus_a.load_err;    o.count = {1'b0, bus_a.load_count}; o.busy = bus_a.busy;
            o.ready = bus_a.load_ready;
        end
    endtask

    task automatic chk_reset(input bit b, input string tag);
        out_t o;
        sample(b, o);
        chk({tag, ".busy"},  o.busy,  1);
        chk({tag, ".valid"}, o.valid, 0);
        chk({tag, ".instr"}, o.instr, 16'hF000);
        chk({tag, ".ferr"},  o.ferr,  0);
        chk({tag, ".lerr"},  o.lerr,  0);
        chk({tag, ".count"}, o.count, 0);
        chk({tag, ".ready"}, o.ready, 0);
    endtask

    task automatic count_busy(input bit b, output int cnt);
        out_t o;
        cnt = 0;
        sample(b, o);
        while (o.busy && cnt < 200) begin
            cnt++;
            step();
            sample(b, o);
        end
    endtask

    task automatic apply_vec(input bit b, input vec_t v);
        out_t o;
        drive(b, v.fr, v.fa, v.le, v.lv, v.la, v.ld);
        #1;
        sample(b, o);
        chk({v.nm, ".ready"}, o.ready, v.rdy);
        step();
        sample(b, o);
        chk({v.nm, ".valid"}, o.valid, v.ev);
        chk({v.nm, ".instr"}, o.instr, v.ei);
        chk({v.nm, ".ferr"},  o.ferr,  v.efe);
        chk({v.nm, ".lerr"},  o.lerr,  v.ele);
        chk({v.nm, ".count"}, o.count, v.ec);
        chk({v.nm, ".busy"},  o.busy,  v.eb);
    endtask

    task automatic fetch_chk(input bit b, input string nm, input int addr,
                             input int exp_instr, input bit exp_err);
        out_t o;
        drive(b, 1, addr, 0, 0, 0, 0);
        step();
        sample(b, o);
        chk({nm, ".valid"}, o.valid, 1);
        chk({nm, ".instr"}, o.instr, exp_instr);
        chk({nm, ".ferr"},  o.ferr,  exp_err);
    endtask

    initial begin
        vec_t va[$];
        vec_t vb[$];
        out_t o;
        int   cnt;

        n_chk  = 0;
        n_fail = 0;

        //      name            fr fa  le lv la  ld       rdy ev instr    fe le cnt busy
        va.push_back(mk("a_enter_fetch",  1, 5,  1, 0, 0,  0,       0, 1, 'hF000, 0, 0, 0, 1));
        va.push_back(mk("a_beat1_nofetch",1, 3,  1, 1, 1,  'h0000,  1, 0, 'hF000, 0, 0, 1, 1));
        va.push_back(mk("a_beat2",        0, 0,  1, 1, 2,  'h6000,  1, 0, 'hF000, 0, 0, 2, 1));
        va.push_back(mk("a_beat17",       0, 0,  1, 1, 17, 'h7400,  1, 0, 'hF000, 0, 0, 3, 1));
        va.push_back(mk("a_exit_beat_ign",0, 0,  0, 1, 4,  'h1234,  0, 0, 'hF000, 0, 0, 3, 0));
        va.push_back(mk("a_rd2",          1, 2,  0, 0, 0,  0,       0, 1, 'h6000, 0, 0, 3, 0));
        va.push_back(mk("a_rd1",          1, 1,  0, 0, 0,  0,       0, 1, 'h0000, 0, 0, 3, 0));
        va.push_back(mk("a_rd17",         1, 17, 0, 0, 0,  0,       0, 1, 'h7400, 0, 0, 3, 0));
        va.push_back(mk("a_rd4",          1, 4,  0, 0, 0,  0,       0, 1, 'hF000, 0, 0, 3, 0));
        va.push_back(mk("a_idle",         0, 0,  0, 0, 0,  0,       0, 0, 'hF000, 0, 0, 3, 0));
        va.push_back(mk("a_enter2",       0, 0,  1, 0, 0,  0,       0, 0, 'hF000, 0, 0, 3, 1));
        va.push_back(mk("a_beat9",        0, 0,  1, 1, 9,  'hABCD,  1, 0, 'hF000, 0, 0, 1, 1));
        va.push_back(mk("a_exit2",        0, 0,  0, 0, 0,  0,       0, 0, 'hF000, 0, 0, 1, 0));
        va.push_back(mk("a_rd9_raw",      1, 9,  0, 0, 0,  0,       0, 1, 'hABCD, 0, 0, 1, 0));
        va.push_back(mk("a_idle2",        0, 0,  0, 0, 0,  0,       0, 0, 'hABCD, 0, 0, 1, 0));

        vb.push_back(mk("b_rd45",         1, 45, 0, 0, 0,  0,       0, 1, 'hF000, 1, 0, 0, 0));
        vb.push_back(mk("b_rd10",         1, 10, 0, 0, 0,  0,       0, 1, 'hF000, 0, 0, 0, 0));
        vb.push_back(mk("b_rd63",         1, 63, 0, 0, 0,  0,       0, 1, 'hF000, 1, 0, 0, 0));
        vb.push_back(mk("b_enter",        0, 0,  1, 0, 0,  0,       0, 0, 'hF000, 0, 0, 0, 1));
        vb.push_back(mk("b_beat50",       0, 0,  1, 1, 50, 'h1111,  1, 0, 'hF000, 0, 1, 0, 1));
        vb.push_back(mk("b_beat39",       0, 0,  1, 1, 39, 'h2222,  1, 0, 'hF000, 0, 0, 1, 1));
        vb.push_back(mk("b_exit",         0, 0,  0, 0, 0,  0,       0, 0, 'hF000, 0, 0, 1, 0));
        vb.push_back(mk("b_rd10_noalias", 1, 10, 0, 0, 0,  0,       0, 1, 'hF000, 0, 0, 1, 0));
        vb.push_back(mk("b_rd39",         1, 39, 0, 0, 0,  0,       0, 1, 'h2222, 0, 0, 1, 0));
        vb.push_back(mk("b_rd50",         1, 50, 0, 0, 0,  0,       0, 1, 'hF000, 1, 0, 1, 0));
        vb.push_back(mk("b_idle",         0, 0,  0, 0, 0,  0,       0, 0, 'hF000, 0, 0, 1, 0));

        // Reset state, with load_en and fetch_req held high to show they are ignored.
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        drive(0, 1, 3, 1, 1, 0, 0);
        drive(1, 1, 3, 1, 1, 0, 0);
        repeat (3) step();
        chk_reset(0, "a_reset");
        chk_reset(1, "b_reset");

        // Instance A: CLEAR length with requests held high, then full NOP readback.
        drive(1, 0, 0, 0, 0, 0, 0);
        rst_n_a = 1'b1;
        count_busy(0, cnt);
        chk("a_clear_cycles", cnt, 32);
        sample(0, o);
        chk("a_clear_fetch_ignored", o.valid, 0);
        for (int i = 0; i < 32; i++) begin
            fetch_chk(0, $sformatf("a_nop_rd%0d", i), i, 'hF000, 0);
        end

        foreach (va[i]) apply_vec(0, va[i]);

        // Saturating beat count with overwriting addresses.
        drive(0, 0, 0, 1, 0, 0, 0);
        step();
        for (int i = 0; i < 70; i++) begin
            drive(0, 0, 0, 1, 1, i % 32, 'h2000 + i);
            step();
            sample(0, o);
            if (i == 39 || i == 61 || i == 62 || i == 63 || i == 69) begin
                chk($sformatf("a_sat_count%0d", i + 1), o.count, (i + 1 > 63) ? 63 : i + 1);
            end
            chk($sformatf("a_sat_lerr%0d", i), o.lerr, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        sample(0, o);
        chk("a_sat_exit_busy", o.busy, 0);
        fetch_chk(0, "a_ovw_rd0", 0, 'h2040, 0);
        fetch_chk(0, "a_ovw_rd7", 7, 'h2027, 0);
        fetch_chk(0, "a_ovw_rd5", 5, 'h2045, 0);

        // Reset mid-LOAD after writing address 2.
        drive(0, 1, 2, 1, 0, 0, 0);
        step();
        sample(0, o);
        chk("a_edge_fetch.valid", o.valid, 1);
        chk("a_edge_fetch.instr", o.instr, 'h2042);
        drive(0, 0, 0, 1, 1, 2, 'h6000);
        #1;
        sample(0, o);
        chk("a_midload.ready", o.ready, 1);
        step();
        sample(0, o);
        chk("a_midload.count", o.count, 1);
        #2;
        rst_n_a = 1'b0;
        #1;
        chk_reset(0, "a_async_reset");
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        rst_n_a = 1'b1;
        count_busy(0, cnt);
        chk("a_reclear_cycles", cnt, 32);
        fetch_chk(0, "a_reclear_rd2", 2, 'hF000, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // Instance B: DEPTH=40 behind a 6-bit address.
        rst_n_b = 1'b1;
        count_busy(1, cnt);
        chk("b_clear_cycles", cnt, 40);
        foreach (vb[i]) apply_vec(1, vb[i]);

        // In-flight fetch killed by asynchronous reset.
        drive(1, 1, 39, 0, 0, 0, 0);
        step();
        sample(1, o);
        chk("b_inflight.valid", o.valid, 1);
        chk("b_inflight.instr", o.instr, 'h2222);
        #2;
        rst_n_b = 1'b0;
        #1;
        chk_reset(1, "b_kill");
        drive(1, 0, 0, 0, 0, 0, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
